urisc_seq_ctrl: RTL and testbench
=================================

Name: urisc_seq_ctrl

Overview:
Multicycle sequencer for the URISC subleq core. It fetches a 64-bit instruction word and splits it into A/B/C fields. It then reads mem[A] and mem[B], writes mem[B] - mem[A] back to B, and branches to C when the result is less than or equal to zero. All accesses go through one shared single-port memory port using a req/ack handshake. It sits between the top level (start/status) and the memory block.

Parameters:
- WORD_W, gc::WORD_SIZE (64): data and instruction width.
- ADDR_W, gc::A_s (20): address and field width.
- MEM_DEPTH, gc::MEM_SIZE (36): number of valid word addresses; legal range is 0..MEM_DEPTH-1.
- HALT_ADDR, all-ones of ADDR_W (0xFFFFF): a taken branch to this address halts the core.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- start, in, 1: begin execution; accepted in IDLE, HALT or FAULT.
- start_pc, in, ADDR_W: initial PC, sampled with start.
- mem_req, out, 1: memory access request.
- mem_we, out, 1: 1 = write, 0 = read.
- mem_addr, out, ADDR_W: access address.
- mem_wdata, out, WORD_W: write data.
- mem_rdata, in, WORD_W: read data, valid when mem_ack is high.
- mem_ack, in, 1: transfer completes on a clock edge where mem_req and mem_ack are both high.
- busy, out, 1: high in all states other than IDLE, HALT and FAULT.
- halted, out, 1: high in HALT.
- fault, out, 1: high in FAULT.
- fault_addr, out, ADDR_W: the out-of-range address that caused the fault.
- pc, out, ADDR_W: current program counter.
- retired, out, 32: count of completed instructions; wraps.

Behaviour:
- Reset (asynchronous, active-low): state goes to IDLE and all outputs go to 0, including mem_req, which drops immediately even mid-transfer. No write completes after reset asserts.
- Instruction fields: A = instr[19:0], B = instr[39:20], C = instr[59:40]. Bits [63:60] are ignored.
- States and transitions:
  - IDLE: on start, go to FETCH with pc = start_pc.
  - FETCH: read at pc. On ack, latch A/B/C and go to RD_A.
  - RD_A: read at A. On ack, latch opa and go to RD_B.
  - RD_B: read at B. On ack, latch opb and go to EXEC.
  - EXEC: one cycle, no memory access. res = opb - opa, in WORD_W two's complement with wraparound. leq = res is zero or its MSB is set. Go to WR_B.
  - WR_B: write res to B, mem_we = 1. On ack, retired increments, then:
    - if leq and C == HALT_ADDR: go to HALT, pc unchanged;
    - else if leq: pc = C, go to FETCH;
    - else: pc = pc + 1 (wraps at ADDR_W), go to FETCH.
  - HALT / FAULT: stay until start. Start clears halted, fault and fault_addr; retired is not cleared.
- Range check in FETCH, RD_A, RD_B and WR_B:
  - If the state's address is >= MEM_DEPTH, mem_req stays low that cycle.
  - The next state is FAULT, with fault_addr = the offending address.
  - pc is not updated.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable from assertion until the ack edge.
  - mem_req deasserts for at least one cycle only when a memory state is left.
  - Back-to-back memory states may keep mem_req high with new address and control values.
  - Ack with mem_req low is ignored.
- Latency: with mem_ack tied high, an instruction takes 5 cycles (FETCH, RD_A, RD_B, EXEC, WR_B). Each extra wait cycle adds one.
- start while busy is ignored.
- A == B is legal: result is 0, so the branch is taken.

Decomposition:
- Shared gc package, new entries:
  - ctrl_state_t enum: IDLE, FETCH, RD_A, RD_B, EXEC, WR_B, HALT, FAULT.
  - HALT_ADDR.
  - Field bounds, reusing A_LB/A_UB etc.
- One natural sub-module: urisc_subleq_alu, combinational. Takes opa and opb; returns res and leq.

Test Plan:
- Reset: hold reset_n low, then release → all outputs 0, state IDLE, and mem_req stays 0 with no start.
- Not-taken: mem[0] = {C=5, B=11, A=10}, mem[10] = 3, mem[11] = 7, ack tied high, start with start_pc = 0 → mem[11] = 4, pc = 1, retired = 1, exactly 5 cycles.
- Taken: same instruction with mem[10] = 7, mem[11] = 7 → mem[11] = 0, pc = 5. A second run with mem[10] = 9 gives mem[11] = 0xFFFF_FFFF_FFFF_FFFE and pc = 5.
- Halt: C = 0xFFFFF, mem[A] = 1, mem[B] = 0 → halted = 1, pc = 0, retired = 1, busy = 0. A later start with start_pc = 2 resumes execution.
- Fault: instruction A = 40 → fault = 1, fault_addr = 40, no request to address 40. Also start_pc = 36 → fault before any fetch.
- Wait states and mid-op reset: ack delayed 3 cycles per access → 17 cycles per instruction, with address and data stable during waits. Asserting reset_n low during RD_B drops mem_req immediately and leaves memory unmodified.

Source files
------------

// File: rtl/urisc_seq_ctrl_pkg.sv
// Shared URISC constants: word/address sizes, memory depth, instruction field
// bounds and the sequencer state encoding.
package urisc_seq_ctrl_pkg;

  localparam int WORD_SIZE = 64;
  localparam int A_s       = 20;
  localparam int MEM_SIZE  = 36;

  localparam logic [A_s-1:0] HALT_ADDR = {A_s{1'b1}};

  // Instruction word layout; bits above C_UB are don't-care.
  localparam int A_LB = 0;
  localparam int A_UB = 19;
  localparam int B_LB = 20;
  localparam int B_UB = 39;
  localparam int C_LB = 40;
  localparam int C_UB = 59;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    RD_A,
    RD_B,
    EXEC,
    WR_B,
    HALT,
    FAULT
  } ctrl_state_t;

endpackage

// File: rtl/urisc_seq_ctrl_if.sv
// Single-port memory req/ack bus between the sequencer (master) and memory (slave).
interface urisc_seq_ctrl_if
  import urisc_seq_ctrl_pkg::*;
#(
  parameter int WORD_W = WORD_SIZE,
  parameter int ADDR_W = A_s
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/urisc_seq_ctrl_alu.sv
// Subleq datapath: res = opb - opa with two's-complement wrap; leq flags res <= 0.
module urisc_subleq_alu
  import urisc_seq_ctrl_pkg::*;
#(
  parameter int WORD_W = WORD_SIZE
) (
  input  logic signed [WORD_W-1:0] i_opa,
  input  logic signed [WORD_W-1:0] i_opb,
  output logic signed [WORD_W-1:0] o_res,
  output logic                     o_leq
);

  assign o_res = i_opb - i_opa;
  assign o_leq = (o_res == '0) || o_res[WORD_W-1];

endmodule

// File: rtl/urisc_seq_ctrl.sv
// Multicycle subleq sequencer: fetch, read A, read B, subtract, write B, branch.
// All memory traffic goes through one req/ack port with registered controls.
module urisc_seq_ctrl
  import urisc_seq_ctrl_pkg::*;
#(
  parameter int WORD_W    = WORD_SIZE,
  parameter int ADDR_W    = A_s,
  parameter int MEM_DEPTH = MEM_SIZE
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_pc,
  urisc_seq_ctrl_if.master   mem,
  output logic               busy,
  output logic               halted,
  output logic               fault,
  output logic [ADDR_W-1:0]  fault_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic [31:0]        retired
);

  ctrl_state_t              r_state;
  logic                     r_req;
  logic                     r_we;
  logic [ADDR_W-1:0]        r_addr;
  logic [WORD_W-1:0]        r_wdata;
  logic [ADDR_W-1:0]        r_pc;
  logic [ADDR_W-1:0]        r_b;
  logic [ADDR_W-1:0]        r_c;
  logic signed [WORD_W-1:0] r_opa;
  logic signed [WORD_W-1:0] r_opb;
  logic                     r_leq;
  logic                     r_busy;
  logic                     r_halted;
  logic                     r_fault;
  logic [ADDR_W-1:0]        r_fault_addr;
  logic [31:0]              r_retired;

  logic [ADDR_W-1:0]        w_fa;
  logic [ADDR_W-1:0]        w_fb;
  logic [ADDR_W-1:0]        w_fc;
  logic [ADDR_W-1:0]        w_next_pc;
  logic signed [WORD_W-1:0] w_res;
  logic                     w_leq;
  logic                     w_mem_state;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return a < ADDR_W'(MEM_DEPTH);
  endfunction

  assign w_fa        = mem.mem_rdata[A_UB:A_LB];
  assign w_fb        = mem.mem_rdata[B_UB:B_LB];
  assign w_fc        = mem.mem_rdata[C_UB:C_LB];
  assign w_next_pc   = r_leq ? r_c : r_pc + ADDR_W'(1);
  assign w_mem_state = (r_state == FETCH) || (r_state == RD_A) ||
                       (r_state == RD_B)  || (r_state == WR_B);

  urisc_subleq_alu #(.WORD_W(WORD_W)) u_alu (
    .i_opa (r_opa),
    .i_opb (r_opb),
    .o_res (w_res),
    .o_leq (w_leq)
  );

  // Controls for the next memory state are set on the edge that enters it, so
  // an out-of-range address never raises mem_req and the state then faults.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_pc         <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_opa        <= '0;
      r_opb        <= '0;
      r_leq        <= 1'b0;
      r_busy       <= 1'b0;
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
      r_retired    <= '0;
    end else if (w_mem_state && !r_req) begin
      r_state      <= FAULT;
      r_we         <= 1'b0;
      r_busy       <= 1'b0;
      r_fault      <= 1'b1;
      r_fault_addr <= r_addr;
    end else begin
      case (r_state)
        IDLE, HALT, FAULT: begin
          if (start) begin
            r_state      <= FETCH;
            r_pc         <= start_pc;
            r_addr       <= start_pc;
            r_we         <= 1'b0;
            r_req        <= addr_ok(start_pc);
            r_busy       <= 1'b1;
            r_halted     <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
          end
        end
        FETCH: begin
          if (mem.mem_ack) begin
            r_b     <= w_fb;
            r_c     <= w_fc;
            r_state <= RD_A;
            r_addr  <= w_fa;
            r_req   <= addr_ok(w_fa);
          end
        end
        RD_A: begin
          if (mem.mem_ack) begin
            r_opa   <= mem.mem_rdata;
            r_state <= RD_B;
            r_addr  <= r_b;
            r_req   <= addr_ok(r_b);
          end
        end
        RD_B: begin
          if (mem.mem_ack) begin
            r_opb   <= mem.mem_rdata;
            r_state <= EXEC;
            r_req   <= 1'b0;
          end
        end
        EXEC: begin
          r_wdata <= w_res;
          r_leq   <= w_leq;
          r_state <= WR_B;
          r_addr  <= r_b;
          r_we    <= 1'b1;
          r_req   <= addr_ok(r_b);
        end
        WR_B: begin
          if (mem.mem_ack) begin
            r_retired <= r_retired + 32'd1;
            r_we      <= 1'b0;
            if (r_leq && (r_c == HALT_ADDR)) begin
              r_state  <= HALT;
              r_req    <= 1'b0;
              r_busy   <= 1'b0;
              r_halted <= 1'b1;
            end else begin
              r_state <= FETCH;
              r_pc    <= w_next_pc;
              r_addr  <= w_next_pc;
              r_req   <= addr_ok(w_next_pc);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;

  assign busy       = r_busy;
  assign halted     = r_halted;
  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;
  assign pc         = r_pc;
  assign retired    = r_retired;

endmodule

// File: tb/tb_urisc_seq_ctrl.sv
// Directed bench for urisc_seq_ctrl with a 64-word memory model and settable ack delay.
module tb_urisc_seq_ctrl;
  import urisc_seq_ctrl_pkg::*;

  localparam logic [19:0] HLT = 20'hFFFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [19:0] start_pc = '0;
  logic        busy, halted, fault;
  logic [19:0] fault_addr, pc;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  urisc_seq_ctrl_if mif ();

  urisc_seq_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_pc   (start_pc),
    .mem        (mif),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault),
    .fault_addr (fault_addr),
    .pc         (pc),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // Memory model with a load port, ack delay and bus monitors
  logic [63:0] mem [0:63];
  logic        ld_en = 1'b0;
  logic [5:0]  ld_addr = '0;
  logic [63:0] ld_data = '0;
  int          wait_n = 0;
  int          wcnt = 0;
  int          n_bad_req = 0;
  int          n_req_cyc = 0;
  int          n_unstable = 0;
  logic        pend = 1'b0;
  logic [19:0] s_addr = '0;
  logic        s_we = 1'b0;
  logic [63:0] s_wdata = '0;

  assign mif.mem_ack   = (wcnt >= wait_n);
  assign mif.mem_rdata = (mif.mem_addr < 20'd64) ? mem[mif.mem_addr[5:0]] : 64'd0;

  always @(posedge clk) begin
    if (ld_en)
      mem[ld_addr] <= ld_data;
    else if (mif.mem_req && mif.mem_ack && mif.mem_we && (mif.mem_addr < 20'd64))
      mem[mif.mem_addr[5:0]] <= mif.mem_wdata;
    if (mif.mem_req && !mif.mem_ack) wcnt <= wcnt + 1;
    else                             wcnt <= 0;
    if (mif.mem_req) n_req_cyc <= n_req_cyc + 1;
    if (mif.mem_req && (mif.mem_addr >= 20'd36)) n_bad_req <= n_bad_req + 1;
    if (reset_n && pend && mif.mem_req &&
        ((mif.mem_addr != s_addr) || (mif.mem_we != s_we) || (mif.mem_wdata != s_wdata)))
      n_unstable <= n_unstable + 1;
    pend    <= reset_n && mif.mem_req && !mif.mem_ack;
    s_addr  <= mif.mem_addr;
    s_we    <= mif.mem_we;
    s_wdata <= mif.mem_wdata;
  end

  function automatic logic [63:0] mk(input logic [19:0] c, input logic [19:0] b, input logic [19:0] a);
    return {4'hA, c, b, a};
  endfunction

  task automatic load(input int a, input logic [63:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 6'(a); ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [19:0] p);
    @(negedge clk);
    start = 1'b1; start_pc = p;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_retire(output int cyc);
    logic [31:0] r0;
    r0  = retired;
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (retired != r0) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic wait_stop(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin
        ok = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int cyc;
    for (int i = 0; i < 64; i++) load(i, 64'd0);
    checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL rst_req_held: got %b want 0", mif.mem_req); end
    @(negedge clk) reset_n = 1'b1;
    cyc = 0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL rst_req_idle: got %b want 0", mif.mem_req); end
    end
    checks++;
    if ({busy, halted, fault, fault_addr, pc, retired, mif.mem_we, mif.mem_addr, mif.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL rst_outputs: busy=%b halted=%b fault=%b fa=%0h pc=%0h ret=%0d we=%b addr=%0h wdata=%0h want all 0",
               busy, halted, fault, fault_addr, pc, retired, mif.mem_we, mif.mem_addr, mif.mem_wdata);
    end
  endtask

  task automatic test_not_taken();
    int cyc; bit ok;
    wait_n = 0;
    load(0, mk(20'd5, 20'd11, 20'd10));
    load(1, mk(HLT, 20'd20, 20'd20));
    load(5, mk(HLT, 20'd20, 20'd20));
    load(10, 64'd3);
    load(11, 64'd7);
    load(20, 64'd123);
    pulse_start(20'd0);
    wait_retire(cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL nt_cycles: got %0d want 5", cyc); end
    checks++; if (mem[11] !== 64'd4) begin errors++; $display("FAIL nt_mem11: got %0h want 4", mem[11]); end
    checks++; if (pc !== 20'd1) begin errors++; $display("FAIL nt_pc: got %0h want 1", pc); end
    checks++; if (retired !== 32'd1) begin errors++; $display("FAIL nt_retired: got %0d want 1", retired); end
    wait_stop(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL nt_stop_timeout: got %b want 1", ok); end
    checks++; if ({halted, fault} !== 2'b10) begin errors++; $display("FAIL nt_halt_aeqb: halted=%b fault=%b want 1 0", halted, fault); end
    checks++; if (pc !== 20'd1 || retired !== 32'd2 || mem[20] !== 64'd0) begin
      errors++; $display("FAIL nt_aeqb_state: pc=%0h ret=%0d mem20=%0h want 1 2 0", pc, retired, mem[20]); end
  endtask

  task automatic test_taken();
    int cyc; bit ok;
    load(10, 64'd7);
    load(11, 64'd7);
    load(20, 64'd5);
    pulse_start(20'd0);
    checks++; if ({busy, halted} !== 2'b10) begin errors++; $display("FAIL tk_restart: busy=%b halted=%b want 1 0", busy, halted); end
    wait_retire(cyc);
    checks++; if (mem[11] !== 64'd0 || pc !== 20'd5 || retired !== 32'd3) begin
      errors++; $display("FAIL tk_zero: mem11=%0h pc=%0h ret=%0d want 0 5 3", mem[11], pc, retired); end
    wait_stop(ok);
    checks++; if (ok !== 1'b1 || halted !== 1'b1 || pc !== 20'd5 || retired !== 32'd4) begin
      errors++; $display("FAIL tk_zero_halt: ok=%b halted=%b pc=%0h ret=%0d want 1 1 5 4", ok, halted, pc, retired); end
    load(10, 64'd9);
    load(11, 64'd7);
    pulse_start(20'd0);
    wait_retire(cyc);
    checks++; if (cyc !== 5 || mem[11] !== 64'hFFFF_FFFF_FFFF_FFFE || pc !== 20'd5) begin
      errors++; $display("FAIL tk_neg: cyc=%0d mem11=%0h pc=%0h want 5 fffffffffffffffe 5", cyc, mem[11], pc); end
    wait_stop(ok);
    checks++; if (ok !== 1'b1 || retired !== 32'd6) begin errors++; $display("FAIL tk_neg_halt: ok=%b ret=%0d want 1 6", ok, retired); end
  endtask

  task automatic test_halt();
    int cyc; bit ok;
    load(0, mk(HLT, 20'd11, 20'd10));
    load(10, 64'd1);
    load(11, 64'd0);
    pulse_start(20'd0);
    wait_retire(cyc);
    checks++; if ({halted, busy, fault} !== 3'b100 || pc !== 20'd0 || retired !== 32'd7) begin
      errors++; $display("FAIL hl_state: halted=%b busy=%b fault=%b pc=%0h ret=%0d want 1 0 0 0 7", halted, busy, fault, pc, retired); end
    checks++; if (mem[11] !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL hl_mem11: got %0h want ffffffffffffffff", mem[11]); end
    load(2, mk(20'd5, 20'd13, 20'd12));
    load(3, mk(HLT, 20'd20, 20'd20));
    load(12, 64'd1);
    load(13, 64'd5);
    pulse_start(20'd2);
    checks++; if ({busy, halted} !== 2'b10 || pc !== 20'd2) begin
      errors++; $display("FAIL hl_resume: busy=%b halted=%b pc=%0h want 1 0 2", busy, halted, pc); end
    wait_retire(cyc);
    checks++; if (mem[13] !== 64'd4 || pc !== 20'd3 || retired !== 32'd8) begin
      errors++; $display("FAIL hl_resume_run: mem13=%0h pc=%0h ret=%0d want 4 3 8", mem[13], pc, retired); end
    wait_stop(ok);
    checks++; if (ok !== 1'b1 || halted !== 1'b1 || retired !== 32'd9) begin
      errors++; $display("FAIL hl_resume_halt: ok=%b halted=%b ret=%0d want 1 1 9", ok, halted, retired); end
  endtask

  task automatic test_fault();
    bit ok; int bad0; int req0;
    bad0 = n_bad_req;
    load(0, mk(20'd5, 20'd11, 20'd40));
    pulse_start(20'd0);
    wait_stop(ok);
    @(posedge clk); #1;
    checks++; if (ok !== 1'b1 || {fault, halted, busy} !== 3'b100) begin
      errors++; $display("FAIL ft_a_state: ok=%b fault=%b halted=%b busy=%b want 1 1 0 0", ok, fault, halted, busy); end
    checks++; if (fault_addr !== 20'd40 || pc !== 20'd0 || retired !== 32'd9) begin
      errors++; $display("FAIL ft_a_vals: fa=%0d pc=%0h ret=%0d want 40 0 9", fault_addr, pc, retired); end
    checks++; if (n_bad_req !== bad0) begin errors++; $display("FAIL ft_a_noreq: bad requests %0d want %0d", n_bad_req, bad0); end
    req0 = n_req_cyc;
    pulse_start(20'd36);
    checks++; if ({fault, busy} !== 2'b01 || fault_addr !== 20'd0) begin
      errors++; $display("FAIL ft_clear: fault=%b busy=%b fa=%0d want 0 1 0", fault, busy, fault_addr); end
    wait_stop(ok);
    @(posedge clk); #1;
    checks++; if (ok !== 1'b1 || fault !== 1'b1 || fault_addr !== 20'd36 || pc !== 20'd36) begin
      errors++; $display("FAIL ft_pc: ok=%b fault=%b fa=%0d pc=%0d want 1 1 36 36", ok, fault, fault_addr, pc); end
    checks++; if (n_req_cyc !== req0) begin errors++; $display("FAIL ft_pc_nofetch: req cycles %0d want %0d", n_req_cyc, req0); end
  endtask

  task automatic test_wait_states();
    int cyc; bit ok; int uns0;
    wait_n = 3;
    uns0 = n_unstable;
    load(0, mk(20'd5, 20'd11, 20'd10));
    load(10, 64'd3);
    load(11, 64'd7);
    pulse_start(20'd0);
    wait_retire(cyc);
    checks++; if (cyc !== 17) begin errors++; $display("FAIL ws_cycles: got %0d want 17", cyc); end
    checks++; if (mem[11] !== 64'd4 || pc !== 20'd1 || retired !== 32'd10) begin
      errors++; $display("FAIL ws_result: mem11=%0h pc=%0h ret=%0d want 4 1 10", mem[11], pc, retired); end
    wait_stop(ok);
    checks++; if (ok !== 1'b1 || halted !== 1'b1 || retired !== 32'd11) begin
      errors++; $display("FAIL ws_halt: ok=%b halted=%b ret=%0d want 1 1 11", ok, halted, retired); end
    checks++; if (n_unstable !== uns0) begin errors++; $display("FAIL ws_stable: unstable events %0d want %0d", n_unstable, uns0); end
  endtask

  task automatic test_reset_mid();
    bit found;
    wait_n = 3;
    load(10, 64'd3);
    load(11, 64'd7);
    pulse_start(20'd0);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (mif.mem_req && !mif.mem_we && mif.mem_addr == 20'd11) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rm_reach_rdb: got %b want 1", found); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (mif.mem_req !== 1'b0 || busy !== 1'b0 || retired !== 32'd0 || pc !== 20'd0) begin
      errors++; $display("FAIL rm_async: req=%b busy=%b ret=%0d pc=%0h want 0 0 0 0", mif.mem_req, busy, retired, pc); end
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mem[11] !== 64'd7 || mif.mem_req !== 1'b0) begin
      errors++; $display("FAIL rm_mem_untouched: mem11=%0h req=%b want 7 0", mem[11], mif.mem_req); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_not_taken();
    test_taken();
    test_halt();
    test_fault();
    test_wait_states();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
